// File: rtl/cpu_pkg.sv
// Shared types and constants for the simple CPU pipeline.
package cpu_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned PC_W   = 16;

  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 16'h0000;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;

  // Sequential fetch address; wraps modulo 2^PC_W.
  function automatic logic [PC_W-1:0] pc_incr(input logic [PC_W-1:0] pc);
    return pc + 1'b1;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {pc, instr} entries; flush overrides push and pop,
// and the head is always read from storage (no write-to-read bypass).
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output fetch_entry_t           head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  fetch_entry_t  store [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        store[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        store[wr_ptr] <= push_data;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head      = store[rd_ptr];
  assign occupancy = count;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch front end: owns the fetch PC, drives the memory read port
// and feeds the fetch queue; redirects flush the queue and restart fetch.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [PC_W-1:0]        mem_raddr,
  input  logic [WORD_W-1:0]      mem_rdata,
  input  logic                   fetch_en,
  input  logic                   redirect_valid,
  input  logic [PC_W-1:0]        redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD_W-1:0]      out_instr,
  output logic [PC_W-1:0]        out_pc,
  output logic [$clog2(DEPTH):0] occupancy
);

  logic [PC_W-1:0] fetch_pc;
  logic            q_full;
  logic            q_empty;
  logic            push;
  logic            pop;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  assign pop  = out_valid & out_ready;
  assign push = fetch_en & ~redirect_valid & (~q_full | pop);

  assign push_entry.pc    = fetch_pc;
  assign push_entry.instr = mem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
    end else if (push) begin
      fetch_pc <= pc_incr(fetch_pc);
    end
  end

  // Address comes straight from the register so memory sees no input-to-address path.
  assign mem_raddr = fetch_pc;

  fetch_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .full      (q_full),
    .empty     (q_empty),
    .occupancy (occupancy)
  );

  assign out_valid = ~q_empty;
  assign out_instr = head.instr;
  assign out_pc    = head.pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, corner-case
// sequences and random traffic against a queue-based reference model.
module tb_fetch_stage;

  localparam int unsigned DEPTH    = 4;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] mem_raddr;
  logic [15:0] mem_rdata;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic [2:0]  occupancy;

  logic [15:0] mem [65536];
  assign mem_rdata = mem[mem_raddr];

  fetch_stage #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_raddr      (mem_raddr),
    .mem_rdata      (mem_rdata),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .occupancy      (occupancy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } ent_t;

  ent_t        mq[$];
  logic [15:0] mpc;
  logic [15:0] popped[$];

  logic        s_valid;
  logic [15:0] s_pc, s_instr, s_raddr;
  logic [2:0]  s_occ;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mpc = RESET_PC;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fetch_en = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_occ", occupancy, 0);
    chk("rst_raddr", mem_raddr, RESET_PC);
    chk("rst_instr", out_instr, 0);
    chk("rst_pc", out_pc, 0);
    rst_n = 1'b1;
    model_reset();
  endtask

  // One clock cycle: drive inputs, check against the model mid-cycle, advance the model.
  task automatic step(input logic en, input logic rdy, input logic redir, input logic [15:0] rpc);
    bit mpop, mpush;
    fetch_en = en;
    out_ready = rdy;
    redirect_valid = redir;
    redirect_pc = rpc;
    @(negedge clk);
    s_valid = out_valid; s_pc = out_pc; s_instr = out_instr;
    s_raddr = mem_raddr; s_occ = occupancy;
    chk("m_valid", out_valid, mq.size() != 0);
    chk("m_occ", occupancy, mq.size());
    chk("m_raddr", mem_raddr, mpc);
    if (mq.size() != 0) begin
      chk("m_pc", out_pc, mq[0].pc);
      chk("m_instr", out_instr, mq[0].instr);
    end
    if (out_valid && rdy) popped.push_back(out_pc);
    mpop  = (mq.size() != 0) && rdy;
    mpush = en && !redir && ((mq.size() < DEPTH) || mpop);
    if (mpop) void'(mq.pop_front());
    if (redir) begin
      mq.delete();
      mpc = rpc;
    end else if (mpush) begin
      mq.push_back(ent_t'{mpc, mem[mpc]});
      mpc = mpc + 16'd1;
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        en;
    logic        rdy;
    logic        exp_valid;
    logic [15:0] exp_pc;
    logic [2:0]  exp_occ;
    logic [15:0] exp_raddr;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'hA000 + 16'(i);

    tbl[0]  = '{1, 1, 0, 16'd0, 3'd0, 16'd0};
    tbl[1]  = '{1, 1, 1, 16'd0, 3'd1, 16'd1};
    tbl[2]  = '{1, 1, 1, 16'd1, 3'd1, 16'd2};
    tbl[3]  = '{1, 1, 1, 16'd2, 3'd1, 16'd3};
    tbl[4]  = '{1, 0, 1, 16'd3, 3'd1, 16'd4};
    tbl[5]  = '{1, 0, 1, 16'd3, 3'd2, 16'd5};
    tbl[6]  = '{1, 0, 1, 16'd3, 3'd3, 16'd6};
    tbl[7]  = '{1, 0, 1, 16'd3, 3'd4, 16'd7};
    tbl[8]  = '{1, 0, 1, 16'd3, 3'd4, 16'd7};
    tbl[9]  = '{1, 1, 1, 16'd3, 3'd4, 16'd7};
    tbl[10] = '{0, 1, 1, 16'd4, 3'd4, 16'd8};
    tbl[11] = '{0, 1, 1, 16'd5, 3'd3, 16'd8};
    tbl[12] = '{1, 0, 1, 16'd6, 3'd2, 16'd8};

    // Directed vectors: stream, fill, full with pop, drain with fetch disabled.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].en, tbl[i].rdy, 1'b0, 16'h0);
      chk($sformatf("t%0d_valid", i), s_valid, tbl[i].exp_valid);
      chk($sformatf("t%0d_occ", i), s_occ, tbl[i].exp_occ);
      chk($sformatf("t%0d_raddr", i), s_raddr, tbl[i].exp_raddr);
      if (tbl[i].exp_valid) begin
        chk($sformatf("t%0d_pc", i), s_pc, tbl[i].exp_pc);
        chk($sformatf("t%0d_instr", i), s_instr, 16'hA000 + tbl[i].exp_pc);
      end
    end

    // Backpressure, then one simultaneous pop while full, then drain.
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 16'h0);
    chk("bp_occ", s_occ, 3'd4);
    chk("bp_raddr", s_raddr, 16'd4);
    chk("bp_head", s_pc, 16'd0);
    popped.delete();
    step(1'b1, 1'b1, 1'b0, 16'h0);
    chk("fp_npop", popped.size(), 1);
    if (popped.size() >= 1) chk("fp_popped", popped[0], 16'd0);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    chk("fp_occ", s_occ, 3'd4);
    chk("fp_raddr", s_raddr, 16'd5);
    chk("fp_head", s_pc, 16'd1);
    popped.delete();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 16'h0);
    chk("dr_npop", popped.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < popped.size()) chk($sformatf("dr_pc%0d", i), popped[i], 16'(i + 1));

    // Redirect mid-stream at occupancy 3 with a concurrent pop.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 16'h0);
    popped.delete();
    step(1'b1, 1'b1, 1'b1, 16'h0100);
    chk("rd_occ", s_occ, 3'd3);
    chk("rd_npop", popped.size(), 1);
    if (popped.size() >= 1) chk("rd_popped", popped[0], 16'd0);
    step(1'b1, 1'b1, 1'b0, 16'h0);
    chk("rd_n1_valid", s_valid, 1'b0);
    chk("rd_n1_raddr", s_raddr, 16'h0100);
    step(1'b1, 1'b1, 1'b0, 16'h0);
    chk("rd_n2_valid", s_valid, 1'b1);
    chk("rd_n2_pc", s_pc, 16'h0100);

    // PC wrap-around through 16'hFFFF.
    step(1'b1, 1'b1, 1'b1, 16'hFFFE);
    popped.delete();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 16'h0);
    chk("wr_npop", popped.size() >= 4, 1'b1);
    if (popped.size() >= 4) begin
      chk("wr_pc0", popped[0], 16'hFFFE);
      chk("wr_pc1", popped[1], 16'hFFFF);
      chk("wr_pc2", popped[2], 16'h0000);
      chk("wr_pc3", popped[3], 16'h0001);
    end

    // Asynchronous reset while full, between clock edges.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 16'h0);
    chk("ar_full", s_occ, 3'd4);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", out_valid, 1'b0);
    chk("ar_occ", occupancy, 0);
    chk("ar_raddr", mem_raddr, RESET_PC);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    // Random traffic, including redirects near the wrap point and memory rewrites.
    for (int i = 0; i < 2000; i++) begin
      logic        en, rdy, redir;
      logic [15:0] rpc;
      en    = ($urandom_range(0, 9) < 8);
      rdy   = ($urandom_range(0, 9) < 6);
      redir = ($urandom_range(0, 19) == 0);
      rpc   = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3)) : 16'($urandom);
      step(en, rdy, redir, rpc);
      if ($urandom_range(0, 3) == 0) mem[mpc + 16'($urandom_range(0, 3))] = 16'($urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch front end for the simple CPU.
- Drives the instruction read port (raddr0/rdata0) of the simple CPU memory, which has combinational reads and 16-bit word addressing.
- Buffers fetched words with their PCs in a small queue and presents them to decode over a valid/ready handshake.
- Accepts redirects (branches/jumps) from execute, which flush the queue and restart fetch.

Parameters:
- DEPTH, 4, queue entries; power of two, at least 2.
- RESET_PC, 16'h0000, first fetch address after reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_raddr  out  16  word address to memory read port 0.
- mem_rdata  in  16  instruction word returned combinationally for mem_raddr in the same cycle.
- fetch_en  in  1  when low, no new words are fetched; the queue still drains.
- redirect_valid  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  16  new fetch address.
- out_valid  out  1  queue head is valid.
- out_ready  in  1  decode accepts the head this cycle.
- out_instr  out  16  head instruction word.
- out_pc  out  16  address the head word was fetched from.
- occupancy  out  log2(DEPTH)+1  current number of queue entries.

Behaviour:
- Reset (asynchronous assert, synchronous-release usage):
  - fetch_pc = RESET_PC, queue empty, occupancy = 0.
  - out_valid = 0; out_instr = 0; out_pc = 0.
- mem_raddr = fetch_pc, driven directly from the register with no combinational path from any input.
- Push condition: push = fetch_en & ~redirect_valid & (occupancy < DEPTH | pop).
  - On push, entry {fetch_pc, mem_rdata} is written at the tail.
  - fetch_pc <= fetch_pc + 1, modulo 2^16, so 16'hFFFF wraps to 16'h0000 with no error.
- Pop: pop = out_valid & out_ready.
  - out_valid = (occupancy != 0).
  - out_instr and out_pc show the head entry combinationally from queue storage.
  - Head data must stay stable while out_valid=1 and out_ready=0.
- Simultaneous push and pop:
  - Allowed when full and when empty+1 (for example, occupancy 1 with pop and push).
  - occupancy is unchanged.
  - When empty, a push never bypasses to the outputs in the same cycle; the word becomes visible the next cycle. Fetch-to-decode latency is 1 cycle.
- Redirect at cycle N:
  - A pop in cycle N still completes, because decode consumed the head.
  - At the edge ending N: the queue is flushed (occupancy = 0), fetch_pc <= redirect_pc, and no push occurs.
  - N+1: mem_raddr = redirect_pc and out_valid = 0.
  - N+2: out_valid = 1 with out_pc = redirect_pc, provided fetch_en was high in N+1.
- Redirect during a full/stall state: flush takes priority; queue contents are discarded.
- fetch_en low: fetch_pc holds and there are no pushes; the queue drains normally. A redirect is still honoured.
- Full with no pop: fetch_pc holds, mem_raddr is stable, and mem_rdata is ignored.
- occupancy range is 0..DEPTH; it never exceeds DEPTH or underflows.
- Pointer arithmetic: read/write pointers are log2(DEPTH) bits wide and wrap naturally; full/empty is derived from occupancy.
- Memory writes from the store path may change mem_rdata. Already-queued words are not re-fetched; self-modifying code requires a redirect.

Decomposition:
- Shared package cpu_pkg:
  - WORD_W = 16, PC_W = 16, RESET_PC_DEFAULT.
  - typedef fetch_entry_t = {pc, instr}.
- One sub-module, fetch_queue: a synchronous FIFO of fetch_entry_t with push, pop, flush, head outputs and occupancy.
  - Flush has priority over push.
  - Pop data is registered in storage, not bypassed.
- fetch_stage owns fetch_pc, the push/redirect control and the memory address.

Test Plan:
- Reset then stream: rst_n low 3 cycles, release, fetch_en=1, out_ready=1, memory words 0..7 = 16'hA000+i.
  - Expect: out_valid first high at cycle 2 after release.
  - Expect: out_pc 0,1,2,… consecutive, out_instr = 16'hA000+pc, one per cycle.
- Backpressure: out_ready=0 for 10 cycles.
  - Expect: occupancy reaches 4 and stays; mem_raddr frozen at 4.
  - Expect: head holds pc=0.
  - Then out_ready=1: pcs 0,1,2,3,4… with no gap or duplicate.
- Full with simultaneous pop: at occupancy 4, pulse out_ready for 1 cycle.
  - Expect: occupancy stays 4, fetch_pc advances by 1, popped pc=0, new tail pc=4.
- Redirect mid-stream: at occupancy 3, assert redirect_valid with redirect_pc=16'h0100 and out_ready=1.
  - Expect: head accepted that cycle.
  - Expect: next cycle out_valid=0 and mem_raddr=16'h0100.
  - Expect: following cycle out_pc=16'h0100.
- Wrap-around: redirect_pc=16'hFFFE.
  - Expect: out_pc sequence FFFE, FFFF, 0000, 0001.
- Reset mid-operation: drop rst_n asynchronously while full and between clock edges.
  - Expect: out_valid=0, occupancy=0 and mem_raddr=RESET_PC immediately, without waiting for a clock edge.
